// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide engine.
package alu_ctrl_pkg;

    // Op class from the main control unit
    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    // R-type funct codes
    localparam logic [5:0] FN_AND   = 6'b000000;
    localparam logic [5:0] FN_SUB   = 6'b000001;
    localparam logic [5:0] FN_OR    = 6'b000010;
    localparam logic [5:0] FN_XOR   = 6'b000011;
    localparam logic [5:0] FN_SLT   = 6'b000100;
    localparam logic [5:0] FN_SRL   = 6'b000101;
    localparam logic [5:0] FN_SRA   = 6'b000110;
    localparam logic [5:0] FN_ADD   = 6'b000111;
    localparam logic [5:0] FN_MULTU = 6'b001000;
    localparam logic [5:0] FN_DIVU  = 6'b001001;

    // ALU control words
    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SRL = 4'b0011;
    localparam logic [3:0] ALUC_SRA = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

    // True for the funct codes handled by the multi-cycle engine
    function automatic logic is_md_fn(input logic [5:0] fn);
        return (fn == FN_MULTU) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_md_iter_core.sv
// Iterative one-bit-per-cycle MULTU/DIVU datapath with HI/LO result registers.
// Multiply: {acc,q} is shifted right, adding the multiplicand into acc when q[0]=1.
// Divide: restoring division, acc holds the partial remainder, q the dividend/quotient.
// Both leave the high half in acc and the low half in q, so commit is shared.
module md_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_mul,
    input  logic             i_load_div,
    input  logic             i_step,
    input  logic             i_commit,
    input  logic             i_commit_dbz,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic             r_div;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // One iteration of either algorithm, selected by the latched mode
    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, r_dsr};
        w_shift   = {r_acc, r_q[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_dsr});
        w_diff    = w_shift[WIDTH-1:0] - r_dsr;
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (r_div) begin
            w_acc_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
        end else if (r_q[0]) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
            w_q_nxt   = {r_acc[0], r_q[WIDTH-1:1]};
        end
    end

    // Operand load, iteration and bit counter; the counter parks at 1 on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 1'b0;
            r_dsr <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load_mul) begin
            r_div <= 1'b0;
            r_dsr <= i_a;
            r_q   <= i_b;
            r_acc <= '0;
            r_cnt <= CNT_INIT;
        end else if (i_load_div) begin
            r_div <= 1'b1;
            r_dsr <= i_b;
            r_q   <= i_a;
            r_acc <= '0;
            r_cnt <= CNT_INIT;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt != CNT_ONE) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // HI/LO capture: final iteration result, or the divide-by-zero convention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_commit_dbz) begin
            r_hi <= i_a;
            r_lo <= '1;
        end else if (i_commit) begin
            r_hi <= w_acc_nxt;
            r_lo <= w_q_nxt;
        end
    end

    assign o_last = (r_cnt == CNT_ONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU control: combinational ALUcnt decode plus the MULTU/DIVU sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | no multi-cycle op in flight; a MULTU/DIVU in EX may start
// MD_MUL  | shift-add multiply, one multiplier bit per cycle, stalling
// MD_DIV  | restoring divide, one quotient bit per cycle, stalling
// MD_DONE | HI/LO were written on entry; md_done pulse, pipeline released
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [5:0]         Function,
    input  logic               ex_valid,
    input  logic               flush,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [CNT_W-1:0]   ALUcnt,
    output logic               stall,
    output logic               md_done,
    output logic               md_dbz,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo
);

    md_state_t r_state;
    md_state_t w_state_nxt;
    logic      r_dbz;

    logic [3:0] w_alucnt;
    logic       w_rtype;
    logic       w_start;
    logic       w_b_zero;
    logic       w_last;
    logic       w_load_mul;
    logic       w_load_div;
    logic       w_step;
    logic       w_commit;
    logic       w_commit_dbz;

    // ALU control decode; depends only on ALUOp/Function, never on the sequencer
    always_comb begin
        w_alucnt = ALUC_AND;
        case (ALUOp)
            ALUOP_W'(ALUOP_RTYPE): begin
                case (Function)
                    FN_AND:  w_alucnt = ALUC_AND;
                    FN_SUB:  w_alucnt = ALUC_SUB;
                    FN_OR:   w_alucnt = ALUC_OR;
                    FN_XOR:  w_alucnt = ALUC_XOR;
                    FN_SLT:  w_alucnt = ALUC_SLT;
                    FN_SRL:  w_alucnt = ALUC_SRL;
                    FN_SRA:  w_alucnt = ALUC_SRA;
                    FN_ADD:  w_alucnt = ALUC_ADD;
                    default: w_alucnt = ALUC_ADD;
                endcase
            end
            ALUOP_W'(ALUOP_SUB): w_alucnt = ALUC_SUB;
            ALUOP_W'(ALUOP_SLT): w_alucnt = ALUC_SLT;
            default:             w_alucnt = ALUC_AND;
        endcase
    end

    assign ALUcnt   = CNT_W'(w_alucnt);
    assign w_rtype  = (ALUOp == ALUOP_W'(ALUOP_RTYPE));
    assign w_b_zero = (B == '0);
    assign w_start  = ex_valid && !flush && (r_state == MD_IDLE) && w_rtype && is_md_fn(Function);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath strobes, stall and done; flush aborts from any state
    always_comb begin
        w_state_nxt  = r_state;
        w_load_mul   = 1'b0;
        w_load_div   = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        w_commit_dbz = 1'b0;
        stall        = 1'b0;
        md_done      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_start) begin
                    stall = 1'b1;
                    if (Function == FN_MULTU) begin
                        w_load_mul  = 1'b1;
                        w_state_nxt = MD_MUL;
                    end else if (w_b_zero) begin
                        w_commit_dbz = 1'b1;
                        w_state_nxt  = MD_DONE;
                    end else begin
                        w_load_div  = 1'b1;
                        w_state_nxt = MD_DIV;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                if (flush) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    stall  = 1'b1;
                    w_step = 1'b1;
                    if (w_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                md_done     = 1'b1;
                w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Divide-by-zero flag: cleared by every start, set only by a zero-divisor start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbz <= 1'b0;
        end else if (w_start) begin
            r_dbz <= w_commit_dbz;
        end
    end

    assign md_dbz = r_dbz;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_md_iter_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_mul   (w_load_mul),
        .i_load_div   (w_load_div),
        .i_step       (w_step),
        .i_commit     (w_commit),
        .i_commit_dbz (w_commit_dbz),
        .i_clear      (flush),
        .i_a          (A),
        .i_b          (B),
        .o_last       (w_last),
        .o_hi         (Hi),
        .o_lo         (Lo)
    );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: decode sweep, MULTU/DIVU latency and
// results through an expected-result queue, divide-by-zero, flush and async reset.
module tb_alu_exec_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [2:0]   ALUOp;
    logic [5:0]   Function;
    logic         ex_valid;
    logic         flush;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUcnt;
    logic         stall;
    logic         md_done;
    logic         md_dbz;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_exec_ctrl #(.WIDTH(W), .CNT_W(4), .ALUOP_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ALUOp    (ALUOp),
        .Function (Function),
        .ex_valid (ex_valid),
        .flush    (flush),
        .A        (A),
        .B        (B),
        .ALUcnt   (ALUcnt),
        .stall    (stall),
        .md_done  (md_done),
        .md_dbz   (md_dbz),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every md_done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && md_done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_md_done at %0t: no operation outstanding", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Hi !== e.hi || Lo !== e.lo || md_dbz !== e.dbz) begin
                    n_fail++;
                    $display("FAIL md_result: got Hi=%h Lo=%h dbz=%b, expected Hi=%h Lo=%h dbz=%b",
                             Hi, Lo, md_dbz, e.hi, e.lo, e.dbz);
                end
            end
        end
    end

    task automatic drive_idle();
        ex_valid = 1'b0;
        flush    = 1'b0;
        ALUOp    = 3'b000;
        Function = 6'b000000;
    endtask

    // Present an MD instruction, queue its expected result and wait for md_done
    task automatic run_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n_stall, output int done_at);
        exp_t         e;
        logic [2*W-1:0] prod;
        if (fn == FN_MULTU) begin
            prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.hi  = prod[2*W-1:W];
            e.lo  = prod[W-1:0];
            e.dbz = 1'b0;
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        ex_valid = 1'b1;
        flush    = 1'b0;
        ALUOp    = ALUOP_RTYPE;
        Function = fn;
        A        = a;
        B        = b;
        n_stall  = 0;
        done_at  = -1;
        for (int c = 0; c < W + 10; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (md_done) begin
                done_at = c;
                break;
            end
        end
        if (done_at < 0) void'(sb.pop_back());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        A = '0;
        B = '0;
        #3;
        n_checks++;
        if (Hi !== '0 || Lo !== '0 || md_done !== 1'b0 || md_dbz !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got Hi=%h Lo=%h done=%b dbz=%b stall=%b, expected all zero",
                     Hi, Lo, md_done, md_dbz, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [2:0] t_op  [15];
        logic [5:0] t_fn  [15];
        logic [3:0] t_exp [15];
        t_op  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                  3'd1, 3'd2, 3'd3, 3'd7};
        t_fn  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'h20,
                  6'd8, 6'd9, 6'd8, 6'd9};
        t_exp = '{4'b0000, 4'b0001, 4'b0101, 4'b0110, 4'b0111, 4'b0011, 4'b0100, 4'b0010,
                  4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0111, 4'b0000, 4'b0000};
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            ALUOp    = t_op[i];
            Function = t_fn[i];
            ex_valid = !(t_op[i] == 3'd0 && (t_fn[i] == 6'd8 || t_fn[i] == 6'd9));
            flush    = 1'b0;
            @(negedge clk);
            n_checks++;
            if (ALUcnt !== t_exp[i] || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL decode[%0d]: op=%b fn=%b got ALUcnt=%b stall=%b, expected ALUcnt=%b stall=0",
                         i, t_op[i], t_fn[i], ALUcnt, stall, t_exp[i]);
            end
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_multu();
        int ns, da;
        run_md(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, da);
        n_checks++;
        if (ns !== 33 || da !== 33) begin
            n_fail++;
            $display("FAIL multu_latency: got stall_cycles=%0d done_at=%0d, expected 33/33", ns, da);
        end
        n_checks++;
        if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max: got Hi=%h Lo=%h, expected fffffffe/00000001", Hi, Lo);
        end
    endtask

    task automatic test_back_to_back();
        int ns, da;
        run_md(FN_DIVU, 32'd100, 32'd7, ns, da);
        n_checks++;
        if (ns !== 33 || da !== 33 || Lo !== 32'd14 || Hi !== 32'd2 || md_dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_100_7: got stall=%0d done=%0d Lo=%0d Hi=%0d dbz=%b, expected 33 33 14 2 0",
                     ns, da, Lo, Hi, md_dbz);
        end
        run_md(FN_DIVU, 32'hDEAD_BEEF, 32'd1234, ns, da);
        n_checks++;
        if (ns !== 33 || da !== 33) begin
            n_fail++;
            $display("FAIL divu_back_to_back: got stall=%0d done_at=%0d, expected 33/33", ns, da);
        end
        run_md(FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF1, ns, da);
        n_checks++;
        if (da !== 33) begin
            n_fail++;
            $display("FAIL multu_after_divu: got done_at=%0d, expected 33", da);
        end
    endtask

    task automatic test_dbz();
        int ns, da;
        run_md(FN_DIVU, 32'h0000_1234, 32'd0, ns, da);
        n_checks++;
        if (ns !== 1 || da !== 1) begin
            n_fail++;
            $display("FAIL dbz_latency: got stall_cycles=%0d done_at=%0d, expected 1/1", ns, da);
        end
        n_checks++;
        if (Hi !== 32'h1234 || Lo !== 32'hFFFF_FFFF || md_dbz !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_result: got Hi=%h Lo=%h dbz=%b, expected 00001234/ffffffff/1", Hi, Lo, md_dbz);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (md_dbz !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_sticky: got md_dbz=%b, expected 1", md_dbz);
        end
        run_md(FN_MULTU, 32'd3, 32'd5, ns, da);
        n_checks++;
        if (md_dbz !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd15) begin
            n_fail++;
            $display("FAIL dbz_cleared: got dbz=%b Hi=%h Lo=%h, expected 0/0/f", md_dbz, Hi, Lo);
        end
    endtask

    task automatic test_flush();
        int ns, da, n_done;
        run_md(FN_DIVU, 32'h0000_BBAA, 32'h0000_0100, ns, da);
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ALUOp    = ALUOP_RTYPE;
        Function = FN_MULTU;
        A        = 32'd12345;
        B        = 32'd678;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall_drop: got stall=%b, expected 0", stall);
        end
        @(posedge clk); #1;
        drive_idle();
        n_done = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (md_done || stall) n_done++;
        end
        n_checks++;
        if (n_done !== 0 || Hi !== 32'hAA || Lo !== 32'hBB) begin
            n_fail++;
            $display("FAIL flush_abort: got done/stall cycles=%0d Hi=%h Lo=%h, expected 0 aa bb", n_done, Hi, Lo);
        end
        @(posedge clk); #1;
        ex_valid = 1'b1;
        Function = FN_MULTU;
        flush    = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_suppresses_start: got stall=%b done=%b, expected 0/0", stall, md_done);
        end
        run_md(FN_MULTU, 32'd3, 32'd4, ns, da);
        n_checks++;
        if (da !== 33) begin
            n_fail++;
            $display("FAIL idle_after_flush: got done_at=%0d, expected 33", da);
        end
    endtask

    task automatic test_async_reset();
        int ns, da;
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ALUOp    = ALUOP_RTYPE;
        Function = FN_DIVU;
        A        = 32'd1000;
        B        = 32'd3;
        repeat (6) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        #1;
        n_checks++;
        if (Hi !== '0 || Lo !== '0 || md_done !== 1'b0 || md_dbz !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got Hi=%h Lo=%h done=%b dbz=%b stall=%b, expected all zero",
                     Hi, Lo, md_done, md_dbz, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || md_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got stall=%b done=%b, expected 0/0", stall, md_done);
        end
        run_md(FN_MULTU, 32'd2, 32'd3, ns, da);
        n_checks++;
        if (da !== 33 || Lo !== 32'd6 || Hi !== 32'd0) begin
            n_fail++;
            $display("FAIL multu_after_reset: got done_at=%0d Hi=%h Lo=%h, expected 33 0 6", da, Hi, Lo);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_multu();
        test_back_to_back();
        test_dbz();
        test_flush();
        test_async_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding results, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
